// File: rtl/mem_arbiter_n.sv
// Round-robin arbiter that shares one single-port synchronous RAM among NCORES channels.
// Same-address reads can be merged into a single RAM access and returned to every requester.
module mem_arbiter_n #(
  parameter int NCORES = 4,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int BCAST  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    rden,
  input  logic [NCORES-1:0]    wren,
  input  logic [NCORES*AW-1:0] Address,
  input  logic [NCORES*DW-1:0] Din,
  input  logic [DW-1:0]        RAMq,
  output logic [NCORES-1:0]    acq,
  output logic [NCORES*DW-1:0] Dq,
  output logic [AW-1:0]        RAMAddress,
  output logic [DW-1:0]        RAMDin,
  output logic                 RAMwren,
  output logic                 busy
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     owner;
  logic              is_wr;
  logic [NCORES-1:0] grp;

  logic [NCORES-1:0] req;
  logic [AW-1:0]     addr_a [NCORES];
  logic [DW-1:0]     din_a  [NCORES];
  logic [PW:0]       cand;
  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic              win_wr;
  logic [NCORES-1:0] grp_n;
  logic [PW-1:0]     ptr_nxt;

  assign req = rden | wren;

  for (genvar g = 0; g < NCORES; g++) begin : g_unpack
    assign addr_a[g] = Address[g*AW +: AW];
    assign din_a[g]  = Din[g*DW +: DW];
  end

  // Search starts at ptr and wraps at NCORES, so non-power-of-two counts stay in range.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NCORES; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NCORES))
        cand = cand - (PW+1)'(NCORES);
      if (!win_found && req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  // A write wins over a read on the same channel; only pure reads may join a read group.
  always_comb begin
    win_wr         = wren[win_idx];
    grp_n          = '0;
    grp_n[win_idx] = 1'b1;
    if (BCAST != 0 && !win_wr) begin
      for (int j = 0; j < NCORES; j++) begin
        if (rden[j] && !wren[j] && (addr_a[j] == addr_a[win_idx]))
          grp_n[j] = 1'b1;
      end
    end
  end

  assign ptr_nxt = (owner == PW'(NCORES-1)) ? '0 : owner + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      owner      <= '0;
      is_wr      <= 1'b0;
      grp        <= '0;
      acq        <= '0;
      Dq         <= '0;
      RAMAddress <= '0;
      RAMDin     <= '0;
      RAMwren    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          acq <= '0;
          if (win_found) begin
            owner      <= win_idx;
            is_wr      <= win_wr;
            grp        <= grp_n;
            RAMAddress <= addr_a[win_idx];
            RAMDin     <= din_a[win_idx];
            RAMwren    <= win_wr;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          RAMwren <= 1'b0;
          if (is_wr) begin
            acq   <= grp;
            state <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          for (int j = 0; j < NCORES; j++) begin
            if (grp[j])
              Dq[j*DW +: DW] <= RAMq;
          end
          acq   <= grp;
          state <= S_DONE;
        end
        S_DONE: begin
          acq   <= '0;
          ptr   <= ptr_nxt;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
